// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period symbols, receiver FSM states and
// the control-symbol classifier used by both encode and decode paths.
package tmds_pkg;

  // Control symbols indexed by {c1,c0}
  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  function automatic logic is_ctrl_symbol(input logic [9:0] sym);
    return (sym == CTRL_00) || (sym == CTRL_01) ||
           (sym == CTRL_10) || (sym == CTRL_11);
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: classifies a 10-bit symbol as control or
// data and recovers either the {c1,c0} pair or the 8-bit pixel byte.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] symbol_i,
  output logic       is_ctrl_o,
  output logic [1:0] c_o,
  output logic [7:0] data_o
);

  logic [7:0] q_raw;

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave a value
    // unassigned, which would otherwise infer a latch.
    is_ctrl_o = is_ctrl_symbol(symbol_i);
    c_o       = 2'b00;
    data_o    = '0;
    case (symbol_i)
      CTRL_01: c_o = 2'b01;
      CTRL_10: c_o = 2'b10;
      CTRL_11: c_o = 2'b11;
      default: c_o = 2'b00;
    endcase
    q_raw     = symbol_i[9] ? ~symbol_i[7:0] : symbol_i[7:0];
    data_o[0] = q_raw[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = symbol_i[8] ? (q_raw[i] ^ q_raw[i-1])
                              : ~(q_raw[i] ^ q_raw[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// Single-channel TMDS receiver: deserialises the bit stream, aligns to the
// word boundary using control symbols, and reports decoded words once locked.
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int LOCK_WORDS = 8,
  parameter int GAP_WORDS  = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tmds_serial_i,
  output logic       word_valid_o,
  output logic [7:0] data_out_o,
  output logic       de_o,
  output logic       c0_o,
  output logic       c1_o,
  output logic [9:0] symbol_out_o,
  output logic       locked_o
);

  localparam int MCW = $clog2(LOCK_WORDS + 1);
  localparam int GCW = $clog2(GAP_WORDS + 1);
  localparam logic [MCW-1:0] LOCK_LIMIT = MCW'(LOCK_WORDS);
  localparam logic [GCW-1:0] GAP_LIMIT  = GCW'(GAP_WORDS);
  localparam logic [3:0]     LAST_BIT   = 4'd9;

  logic [9:0]     sr_q, sr_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  rx_state_t      state_q, state_d;
  logic [MCW-1:0] match_cnt_q, match_cnt_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;

  logic       word_valid_q, word_valid_d;
  logic [7:0] data_q, data_d;
  logic       de_q, de_d;
  logic       c0_q, c0_d;
  logic       c1_q, c1_d;
  logic [9:0] symbol_q, symbol_d;
  logic       locked_q, locked_d;

  logic       dec_is_ctrl;
  logic [1:0] dec_c;
  logic [7:0] dec_data;
  logic       boundary;

  tmds_symbol_decode u_decode (
    .symbol_i  (sr_q),
    .is_ctrl_o (dec_is_ctrl),
    .c_o       (dec_c),
    .data_o    (dec_data)
  );

  // sr_q holds a complete symbol when the mod-10 phase reaches its last bit.
  assign boundary = (bit_cnt_q == LAST_BIT);

  // Alignment FSM, counters and next values of the reported word.
  always_comb begin
    sr_d         = {tmds_serial_i, sr_q[9:1]};
    bit_cnt_d    = (bit_cnt_q == LAST_BIT) ? 4'd0 : bit_cnt_q + 4'd1;
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    word_valid_d = 1'b0;
    data_d       = data_q;
    de_d         = de_q;
    c0_d         = c0_q;
    c1_d         = c1_q;
    symbol_d     = symbol_q;
    case (state_q)
      SEARCH: begin
        // Any bit phase may carry a control symbol; a hit fixes the boundary.
        if (dec_is_ctrl) begin
          bit_cnt_d   = 4'd0;
          match_cnt_d = MCW'(1);
          gap_cnt_d   = '0;
          state_d     = (LOCK_WORDS == 1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (dec_is_ctrl) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_d == LOCK_LIMIT) state_d = LOCKED;
          end else begin
            match_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          word_valid_d = 1'b1;
          symbol_d     = sr_q;
          if (dec_is_ctrl) begin
            de_d      = 1'b0;
            c0_d      = dec_c[0];
            c1_d      = dec_c[1];
            gap_cnt_d = '0;
          end else begin
            de_d   = 1'b1;
            data_d = dec_data;
            if (gap_cnt_q != GAP_LIMIT) gap_cnt_d = gap_cnt_q + 1'b1;
            // A long run without blanking means the alignment is suspect.
            if (gap_cnt_d == GAP_LIMIT) begin
              match_cnt_d = '0;
              state_d     = SEARCH;
            end
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      state_q      <= SEARCH;
      match_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      word_valid_q <= 1'b0;
      data_q       <= '0;
      de_q         <= 1'b0;
      c0_q         <= 1'b0;
      c1_q         <= 1'b0;
      symbol_q     <= '0;
      locked_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      word_valid_q <= word_valid_d;
      data_q       <= data_d;
      de_q         <= de_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      symbol_q     <= symbol_d;
      locked_q     <= locked_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign data_out_o   = data_q;
  assign de_o         = de_q;
  assign c0_o         = c0_q;
  assign c1_o         = c1_q;
  assign symbol_out_o = symbol_q;
  assign locked_o     = locked_q;

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Directed bench for tmds_channel_rx: reset, lock, control/data decode,
// failed verification, gap-driven loss of lock and asynchronous reset.
module tb_tmds_channel_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tmds_serial;
  logic       word_valid;
  logic [7:0] data_out;
  logic       de;
  logic       c0;
  logic       c1;
  logic [9:0] symbol_out;
  logic       locked;

  int n_asserts = 0;
  int n_fail    = 0;
  int wv_cnt    = 0;

  // Outputs captured at the most recent word_valid pulse.
  logic [9:0] snap_sym  = '0;
  logic [7:0] snap_data = '0;
  logic       snap_de   = 1'b0;
  logic [1:0] snap_c    = 2'b00;

  always #5 clk = ~clk;

  tmds_channel_rx #(
    .LOCK_WORDS (8),
    .GAP_WORDS  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tmds_serial_i (tmds_serial),
    .word_valid_o  (word_valid),
    .data_out_o    (data_out),
    .de_o          (de),
    .c0_o          (c0),
    .c1_o          (c1),
    .symbol_out_o  (symbol_out),
    .locked_o      (locked)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample outputs on the falling edge, then present the next serial bit.
  task automatic send_bit(input logic b);
    @(negedge clk);
    if (word_valid === 1'b1) begin
      wv_cnt++;
      snap_sym  = symbol_out;
      snap_data = data_out;
      snap_de   = de;
      snap_c    = {c1, c0};
    end
    tmds_serial = b;
  endtask

  task automatic send_bits(input logic [9:0] s, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(s[i]);
  endtask

  task automatic send_sym(input logic [9:0] s);
    send_bits(s, 0, 9);
  endtask

  initial begin
    rst_n       = 1'b0;
    tmds_serial = 1'b0;

    // 1. Reset held for 5 clocks with a toggling line, released mid-stream.
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    rst_n = 1'b1;
    check("rst_word_valid", 16'(word_valid), 16'h0);
    check("rst_data_out",   16'(data_out),   16'h0);
    check("rst_de",         16'(de),         16'h0);
    check("rst_c0",         16'(c0),         16'h0);
    check("rst_c1",         16'(c1),         16'h0);
    check("rst_symbol_out", 16'(symbol_out), 16'h0);
    check("rst_locked",     16'(locked),     16'h0);

    // 2. Garbage bits, then 8 x 0x354; lock appears one clock after the 8th boundary.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_sym(10'h354);
    check("pre_lock_no_wv",    16'(wv_cnt), 16'd0);
    check("pre_lock_locked",   16'(locked), 16'h0);
    send_bit(1'b0);
    check("lock_boundary_clk", 16'(locked), 16'h0);
    send_bit(1'b0);
    check("lock_next_clk",     16'(locked), 16'h1);
    send_bits(10'h354, 2, 9);
    wv_cnt = 0;

    // 3. Control symbols after lock.
    send_sym(10'h0AB);
    check("c00_symbol", 16'(snap_sym), 16'h354);
    check("c00_de",     16'(snap_de),  16'h0);
    check("c00_c",      16'(snap_c),   16'h0);
    send_sym(10'h2AB);
    check("c01_symbol", 16'(snap_sym), 16'h0AB);
    check("c01_c",      16'(snap_c),   16'h1);
    check("c01_de",     16'(snap_de),  16'h0);
    send_sym(10'h100);
    check("c11_symbol", 16'(snap_sym), 16'h2AB);
    check("c11_c",      16'(snap_c),   16'h3);

    // 4. Data symbols: 0x100 -> 0x00, 0x2FF -> 0xFE, control bits held.
    send_sym(10'h2FF);
    check("d100_symbol", 16'(snap_sym),  16'h100);
    check("d100_data",   16'(snap_data), 16'h00);
    check("d100_de",     16'(snap_de),   16'h1);
    check("d100_c_held", 16'(snap_c),    16'h3);
    send_sym(10'h354);
    check("d2ff_data",   16'(snap_data), 16'hFE);
    check("d2ff_de",     16'(snap_de),   16'h1);
    check("d2ff_c_held", 16'(snap_c),    16'h3);
    check("wv_every_word", 16'(wv_cnt),  16'd5);

    // 6. Gap limit of 16 data words drops lock after reporting the 16th.
    wv_cnt = 0;
    for (int i = 0; i < 16; i++) send_sym(10'h100);
    check("gap15_still_locked", 16'(locked), 16'h1);
    check("gap_ctrl_data_held", 16'(snap_data), 16'h00);
    send_bit(1'b0);
    check("gap16_boundary_locked", 16'(locked),     16'h1);
    check("gap16_boundary_wv",     16'(word_valid), 16'h0);
    send_bit(1'b0);
    check("gap16_wv",      16'(word_valid), 16'h1);
    check("gap16_unlock",  16'(locked),     16'h0);
    check("gap16_de",      16'(de),         16'h1);
    check("gap16_symbol",  16'(symbol_out), 16'h100);
    check("gap_wv_count",  16'(wv_cnt),     16'd17);
    send_bits(10'h354, 2, 9);
    for (int i = 0; i < 7; i++) send_sym(10'h354);
    send_bit(1'b0);
    check("relock_boundary", 16'(locked), 16'h0);
    send_bit(1'b0);
    check("relock_next",     16'(locked), 16'h1);
    send_bits(10'h354, 2, 9);
    send_sym(10'h154);
    send_sym(10'h100);
    check("c10_symbol", 16'(snap_sym), 16'h154);
    check("c10_c",      16'(snap_c),   16'h2);

    // 1b. Asynchronous reset while locked clears outputs before the next edge.
    check("pre_async_locked", 16'(locked), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_locked", 16'(locked),     16'h0);
    check("async_symbol", 16'(symbol_out), 16'h0);
    check("async_de",     16'(de),         16'h0);
    check("async_c1",     16'(c1),         16'h0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst_n = 1'b1;

    // 5. Five control symbols then a data word: verification fails.
    wv_cnt = 0;
    for (int i = 0; i < 5; i++) send_sym(10'h154);
    send_sym(10'h100);
    check("verify_fail_locked", 16'(locked), 16'h0);
    for (int i = 0; i < 7; i++) send_sym(10'h154);
    check("verify_restart_locked", 16'(locked), 16'h0);
    check("verify_no_wv",          16'(wv_cnt), 16'd0);
    send_sym(10'h154);
    send_bit(1'b0);
    check("v_lock_boundary", 16'(locked), 16'h0);
    send_bit(1'b0);
    check("v_lock_next",     16'(locked), 16'h1);
    send_bits(10'h154, 2, 9);
    send_sym(10'h354);
    check("v_c10_symbol", 16'(snap_sym), 16'h154);
    check("v_c10_de",     16'(snap_de),  16'h0);
    check("v_c10_c",      16'(snap_c),   16'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
